// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory target for the CPU M-stage (loads, byte-lane stores, address faults, stall).
// Optional feature: define DMEM_RANGE_CHECK_EN to fault accesses outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_BITS).
module dmem_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic [3:0]  memwrite,
  input  logic [1:0]  load_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badadr,
  output logic        stall
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT      stateReg, stateNext;
  logic [3:0] counterReg, counterNext;

  logic [ADDR_BITS-1:0] idxReg;
  logic [3:0]           strbReg;
  logic [31:0]          wdataReg;

  logic                 isStore;
  logic                 loadMisaligned;
  logic                 storeLegal;
  logic                 outOfRange;
  logic                 accessErr;
  logic                 accept;
  logic                 commit;
  logic                 commitWrite;
  logic                 commitRead;
  logic [ADDR_BITS-1:0] reqIdx;
  logic [ADDR_BITS-1:0] commitIdx;
  logic [3:0]           commitStrb;
  logic [31:0]          commitData;

  assign isStore = |memwrite;

  // Word 0 sits at BASE_ADDR; for a size-aligned base this is just the address index bits.
  assign reqIdx = addr[ADDR_BITS+1:2] - BASE_ADDR[ADDR_BITS+1:2];

  assign loadMisaligned = ((load_size == 2'd1) && addr[0]) ||
                          (load_size[1] && (addr[1:0] != 2'b00));

  always_comb begin
    storeLegal = 1'b0;
    case (memwrite)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: storeLegal = 1'b1;
      4'b0011, 4'b1100:                   storeLegal = !addr[0];
      4'b1111:                            storeLegal = (addr[1:0] == 2'b00);
      default:                            storeLegal = 1'b0;
    endcase
  end

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(4) << ADDR_BITS;
  logic [32:0] rangeOffset;
  // A borrow (addr below the base) wraps the 33-bit offset far above SPAN.
  assign rangeOffset = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign outOfRange  = (rangeOffset >= SPAN);
`else
  assign outOfRange = 1'b0;
`endif

  assign accessErr = (isStore ? !storeLegal : loadMisaligned) || outOfRange;

  assign accept = !rst && (stateReg == IDLE) && memen && !accessErr && !flush;

  // The access executes on the edge that enters DONE, never while flushed or in reset.
  assign commit = !rst && ((accept && (WAIT_CYCLES == 0)) ||
                           ((stateReg == BUSY) && !flush && (counterReg == 4'd1)));

  assign commitIdx   = (stateReg == IDLE) ? reqIdx   : idxReg;
  assign commitStrb  = (stateReg == IDLE) ? memwrite : strbReg;
  assign commitData  = (stateReg == IDLE) ? wdata    : wdataReg;
  assign commitWrite = commit && (commitStrb != 4'b0000);
  assign commitRead  = commit && (commitStrb == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      counterReg <= '0;
    end else begin
      stateReg   <= stateNext;
      counterReg <= counterNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    counterNext = counterReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          counterNext = WAIT_INIT;
          stateNext   = (WAIT_CYCLES == 0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          stateNext = IDLE;
        end else begin
          counterNext = counterReg - 4'd1;
          if (counterReg == 4'd1) begin
            stateNext = DONE;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    adel   = 1'b0;
    ades   = 1'b0;
    badadr = '0;
    if (!rst) begin
      case (stateReg)
        IDLE: begin
          if (memen) begin
            if (accessErr) begin
              adel   = !isStore;
              ades   = isStore;
              badadr = addr;
            end else begin
              stall = !flush;
            end
          end
        end
        BUSY:    stall = !flush;
        default: stall = 1'b0;
      endcase
    end
  end

  // Request is captured at acceptance so the commit does not depend on the CPU holding it.
  always_ff @(posedge clk) begin
    if (accept) begin
      idxReg   <= reqIdx;
      strbReg  <= memwrite;
      wdataReg <= wdata;
    end
  end

  // One byte-wide RAM per lane gives native byte-enable writes with a registered read.
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    logic [7:0] laneMem [DEPTH];
    logic [7:0] laneQ;

    always_ff @(posedge clk) begin
      if (commitWrite && commitStrb[gi]) begin
        laneMem[commitIdx] <= commitData[gi*8 +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        laneQ <= '0;
      end else if (commitRead) begin
        laneQ <= laneMem[commitIdx];
      end
    end

    assign rdata[gi*8 +: 8] = laneQ;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder against a word-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned ADDR_BITS   = 12;
  localparam int unsigned WAIT        = 2;
  localparam logic [31:0] BASE        = 32'h0000_0000;
  localparam int          DEPTH_WORDS = 1 << ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memen = 1'b0;
  logic [3:0]  memwrite = 4'b0;
  logic [1:0]  load_size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;
  logic [31:0] badadr;
  logic        stall;

  dmem_responder #(
    .ADDR_BITS  (ADDR_BITS),
    .WAIT_CYCLES(WAIT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memen    (memen),
    .memwrite (memwrite),
    .load_size(load_size),
    .addr     (addr),
    .wdata    (wdata),
    .flush    (flush),
    .rdata    (rdata),
    .adel     (adel),
    .ades     (ades),
    .badadr   (badadr),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ERR, K_DONE, K_ABORT} kindE;
  typedef struct {
    kindE        kind;
    logic        adel;
    logic        ades;
    logic [31:0] badadr;
    logic [31:0] rdata;
    int          stallLen;
  } expT;

  expT         expQ[$];
  logic [31:0] modelMem [int];
  logic [31:0] lastRdata = 32'h0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wordOf(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % DEPTH_WORDS);
  endfunction

  // Legality straight from the rules: loads by natural alignment, stores by allowed strobe shapes.
  function automatic bit accessOk(input bit st, input logic [3:0] s, input logic [1:0] sz,
                                  input logic [31:0] a);
    bit ok;
    int bytes;
    ok = 1'b0;
    if (st) begin
      if ($countones(s) == 1)                ok = 1'b1;
      else if (s == 4'b0011 || s == 4'b1100) ok = (a % 2 == 0);
      else if (s == 4'b1111)                 ok = (a % 4 == 0);
    end else begin
      bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ok = (a % bytes == 0);
    end
`ifdef DMEM_RANGE_CHECK_EN
    if (longint'(a) < longint'(BASE) ||
        longint'(a) - longint'(BASE) >= 4 * longint'(DEPTH_WORDS)) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic goIdle();
    memen    = 1'b0;
    memwrite = 4'b0;
    flush    = 1'b0;
  endtask

  // flushAt: -1 none, 0 flush in the request cycle, k>0 flush k cycles after the request.
  task automatic access(input bit st, input logic [3:0] s, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input int flushAt);
    expT         e;
    bit          seenLow;
    int          w;
    logic [31:0] word;
    memen     = 1'b1;
    memwrite  = st ? s : 4'b0;
    load_size = sz;
    addr      = a;
    wdata     = d;
    flush     = (flushAt == 0);
    e.kind     = K_DONE;
    e.adel     = 1'b0;
    e.ades     = 1'b0;
    e.badadr   = 32'h0;
    e.rdata    = lastRdata;
    e.stallLen = WAIT + 1;
    if (!accessOk(st, s, sz, a)) begin
      e.kind   = K_ERR;
      e.adel   = !st;
      e.ades   = st;
      e.badadr = a;
      expQ.push_back(e);
      @(posedge clk); #1;
      goIdle();
    end else if (flushAt == 0) begin
      @(posedge clk); #1;
      goIdle();
    end else if (flushAt > 0 && flushAt <= WAIT) begin
      e.kind     = K_ABORT;
      e.stallLen = flushAt;
      expQ.push_back(e);
      repeat (flushAt) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      goIdle();
    end else begin
      w = wordOf(a);
      if (st) begin
        word = modelMem[w];
        for (int i = 0; i < 4; i++) begin
          if (s[i]) word[i*8 +: 8] = d[i*8 +: 8];
        end
        modelMem[w] = word;
      end else begin
        lastRdata = modelMem[w];
      end
      e.rdata = lastRdata;
      expQ.push_back(e);
      // Request stays asserted through the completion cycle; it must not be taken again.
      seenLow = 1'b0;
      for (int i = 0; i < 40 && !seenLow; i++) begin
        @(negedge clk);
        if (stall !== 1'b1) seenLow = 1'b1;
      end
      if (!seenLow) begin
        total++;
        bad++;
        $display("FAIL access_timeout: stall still high after 40 cycles at addr %h, required low", a);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic resetAbort(input logic [31:0] a, input logic [31:0] d);
    memen     = 1'b1;
    memwrite  = 4'hF;
    load_size = 2'd2;
    addr      = a;
    wdata     = d;
    flush     = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    goIdle();
    lastRdata = 32'h0;
    @(posedge clk); #1;
  endtask

  // Monitor: pops one expectation per observed error response or end of a stall run.
  expT mon;
  int  stallRun = 0;
  always @(negedge clk) begin
    if (rst) begin
      stallRun = 0;
    end else if (adel === 1'b1 || ades === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_error: adel=%b ades=%b badadr=%h, required no response", adel, ades, badadr);
      end else begin
        mon = expQ.pop_front();
        check("err_kind", 32'(mon.kind == K_ERR), 32'd1);
        check("adel", 32'(adel), 32'(mon.adel));
        check("ades", 32'(ades), 32'(mon.ades));
        check("badadr", badadr, mon.badadr);
        check("err_stall", 32'(stall), 32'd0);
      end
    end else if (stall === 1'b1) begin
      stallRun++;
    end else if (stallRun > 0) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: stall run %0d, required no access", stallRun);
      end else begin
        mon = expQ.pop_front();
        check("done_kind", 32'(mon.kind == K_ERR), 32'd0);
        check("stall_len", 32'(stallRun), 32'(mon.stallLen));
        check("rdata", rdata, mon.rdata);
        check("done_badadr", badadr, 32'h0);
      end
      stallRun = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          wsel;

    // Reset: outputs forced quiet even with requests present.
    rst = 1'b1; memen = 1'b1; load_size = 2'd1; addr = 32'h13;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_adel", 32'(adel), 32'd0);
    check("rst_badadr", badadr, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    load_size = 2'd2; addr = 32'h10;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    memwrite = 4'b1111; addr = 32'h22;
    @(negedge clk);
    check("rst_ades", 32'(ades), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    goIdle();
    @(negedge clk);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;

    // Fill a 32-word pool so every later load reads defined data.
    for (int w = 0; w < 32; w++) access(1'b1, 4'hF, 2'd2, 32'(w * 4), $urandom, -1);

    access(1'b1, 4'hF, 2'd2, 32'h10, 32'hDEADBEEF, -1);
    access(1'b0, 4'h0, 2'd2, 32'h10, 32'h0, -1);
    access(1'b1, 4'hF, 2'd2, 32'h10, 32'h11223344, -1);
    access(1'b1, 4'b0100, 2'd0, 32'h12, 32'h00AA0000, -1);
    access(1'b0, 4'h0, 2'd2, 32'h10, 32'h0, -1);
    access(1'b0, 4'h0, 2'd1, 32'h13, 32'h0, -1);
    access(1'b1, 4'hF, 2'd2, 32'h22, 32'h0, -1);
    access(1'b1, 4'b0011, 2'd2, 32'h11, 32'h0, -1);
    access(1'b1, 4'b0110, 2'd2, 32'h14, 32'h0, -1);
    access(1'b0, 4'h0, 2'd3, 32'h16, 32'h0, -1);
    access(1'b1, 4'hF, 2'd2, 32'h40, 32'h12345678, 2);
    access(1'b0, 4'h0, 2'd2, 32'h40, 32'h0, -1);
    access(1'b1, 4'hF, 2'd2, 32'h40, 32'h87654321, 1);
    access(1'b1, 4'hF, 2'd2, 32'h40, 32'hA5A5A5A5, 0);
    access(1'b0, 4'h0, 2'd0, 32'h41, 32'h0, -1);
    access(1'b0, 4'h0, 2'd1, 32'h42, 32'h0, -1);
    access(1'b0, 4'h0, 2'd2, 32'h4000, 32'h0, -1);
    access(1'b0, 4'h0, 2'd2, 32'hFFFFC004, 32'h0, -1);
    resetAbort(32'h44, 32'hCAFEF00D);
    access(1'b1, 4'hF, 2'd2, 32'h48, 32'h0BADF00D, -1);
    access(1'b0, 4'h0, 2'd2, 32'h44, 32'h0, -1);

    for (int n = 0; n < 150; n++) begin
      r    = $urandom_range(0, 9);
      wsel = $urandom_range(0, 31);
      a    = 32'(wsel * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = a | ($urandom << 14);
      if (r < 4)      access(1'b0, 4'h0, 2'($urandom_range(0, 3)), a, 32'h0, -1);
      else if (r < 8) access(1'b1, 4'($urandom_range(1, 15)), 2'd0, a, $urandom, -1);
      else            access(r[0], 4'($urandom_range(1, 15)), 2'd2, a & 32'hFFFF_FFFC, $urandom,
                             $urandom_range(0, WAIT));
      if ($urandom_range(0, 3) == 0) begin
        goIdle();
        @(posedge clk); #1;
      end
    end

    goIdle();
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
